uart_tx_scheduler: RTL
======================

Name: uart_tx_scheduler

Overview:
Shares one UART byte transmitter, with a valid-pulse in and a done-pulse back, between NumReq requesters. Arbitration is round-robin per packet: once a requester wins, it owns the transmitter until it sends a byte flagged last, so messages never interleave. A watchdog releases a stalled owner or a hung transmitter. The block sits between software/DMA byte sources and the UART TX datapath.

Parameters:
NumReq, 4, number of requesters (2..8)
TimeoutCycles, 65535, watchdog limit in clk cycles; 16-bit counter; 0 disables the watchdog

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
reqValid  input  NumReq  requester i has a byte
reqData  input  8*NumReq  byte of requester i at bits [8i+7:8i]
reqLast  input  NumReq  the byte is the last of its packet
reqReady  output  NumReq  one-hot; byte of i accepted this cycle
txData  output  8  byte to the transmitter, held stable until done
txValid  output  1  one-cycle start pulse to the transmitter
txDone  input  1  one-cycle pulse: transmitter finished the byte
owner  output  $clog2(NumReq)  current or last granted requester
locked  output  1  a packet is in progress
busy  output  1  state != IDLE
timeoutErr  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- Reset values, applied asynchronously: state IDLE; txData=0; txValid=0; reqReady=0; owner=0; locked=0; timeoutErr=0; rrPtr=0; wdCount=0.
- reqReady is combinational from state, lock and reqValid, and is asserted only in IDLE. A handshake completes when reqValid[i] and reqReady[i] are both high.
- IDLE, unlocked: search from rrPtr upward with wrap for the first i with reqValid[i]=1. If one is found in the same cycle: reqReady[i]=1; txData<=reqData[i]; owner<=i; lastHeld<=reqLast[i]; locked<=!reqLast[i]; go to SEND. If none is found, stay in IDLE.
- IDLE, locked: only owner is eligible. Other requesters are never readied, even when valid.
- SEND: txValid=1 for exactly one cycle; then go to WAIT. A txDone arriving in SEND is ignored.
- WAIT: on txDone go to IDLE. If lastHeld=1, then rrPtr<=owner+1 (mod NumReq) and locked<=0.
- Latency: accept at cycle t, txValid at t+1, earliest next accept is the cycle after txDone. At most one byte is in flight.
- Watchdog: wdCount clears on every state change and on every handshake. It increments while in WAIT, or while in IDLE with locked=1 and no owner valid. When wdCount==TimeoutCycles-1 and TimeoutCycles!=0: timeoutErr pulses for 1 cycle; locked<=0; rrPtr<=owner+1; state<=IDLE. The current byte is abandoned; the block does not retry.
- Boundary cases:
  - Single-byte packet (reqLast on the first byte): locked never rises.
  - reqValid dropping mid-packet: the lock persists until the watchdog fires.
  - reset mid-WAIT: txValid is not reissued; the transmitter's own done is ignored after reset.
  - NumReq not a power of two: rrPtr wrap is explicit modulo NumReq.
- txData changes only on a handshake.
- owner keeps its last value in IDLE.

Test Plan:
1. Reset, then req0 sends 0x41 with last=1, txDone 5 cycles after txValid -> reqReady[0] at t, txValid=1 at t+1 with txData=0x41, busy drops the cycle after txDone, locked stays 0 throughout.
2. All four requesters hold valid with last=1 and txDone is returned promptly -> grants 0,1,2,3,0 in order; each reqReady is one-hot and asserted once per grant.
3. req1 sends 3 bytes 0x10,0x11,0x12 (last on 0x12) while req2 holds valid throughout -> req2 is readied only after 0x12's txDone; locked=1 between bytes.
4. TimeoutCycles=8 and txDone is never returned -> timeoutErr pulses exactly 8 cycles after entering WAIT; state returns to IDLE; locked=0; the next grant goes to owner+1.
5. req3 locked after its first byte, then drops valid with TimeoutCycles=8 -> timeoutErr after 8 idle cycles; req0 is granted next.
6. reset asserted in WAIT while req0 is valid -> all outputs go to reset values immediately; a txDone pulse arriving after reset is ignored; req0 is granted on the first clk after reset deasserts.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// Round-robin, packet-locked sharing of one UART byte transmitter among NumReq sources.
// Accept at t, txValid at t+1, next accept after txDone; sources stall on reqReady, watchdog frees hangs.
module uart_tx_scheduler #(
  parameter int NumReq        = 4,
  parameter int TimeoutCycles = 65535
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NumReq-1:0]         reqValid,
  input  logic [8*NumReq-1:0]       reqData,
  input  logic [NumReq-1:0]         reqLast,
  output logic [NumReq-1:0]         reqReady,
  output logic [7:0]                txData,
  output logic                      txValid,
  input  logic                      txDone,
  output logic [$clog2(NumReq)-1:0] owner,
  output logic                      locked,
  output logic                      busy,
  output logic                      timeoutErr
);

  localparam int              OwnW     = $clog2(NumReq);
  localparam logic [OwnW:0]   NumReqW  = (OwnW+1)'(NumReq);
  localparam logic [15:0]     WdLimit  = 16'(TimeoutCycles - 1);
  localparam bit              WdEnable = (TimeoutCycles != 0);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} stateT;

  stateT            state;
  stateT            stateNext;
  logic [OwnW-1:0]  rrPtr;
  logic [OwnW-1:0]  nextPtr;
  logic [OwnW-1:0]  pick;
  logic [OwnW-1:0]  acceptIdx;
  logic [OwnW:0]    sum;
  logic             found;
  logic             accept;
  logic             lastHeld;
  logic [15:0]      wdCount;
  logic             wdActive;
  logic             wdFire;

  // Rotating priority search; the wrap is an explicit subtract so non-power-of-two counts work.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    for (int k = 0; k < NumReq; k++) begin
      sum = {1'b0, rrPtr} + (OwnW+1)'(k);
      if (sum >= NumReqW) sum = sum - NumReqW;
      if (!found && reqValid[sum[OwnW-1:0]]) begin
        found = 1'b1;
        pick  = sum[OwnW-1:0];
      end
    end
  end

  // Held low during reset so a source never mistakes a reset cycle for an accept.
  always_comb begin
    reqReady = '0;
    if (!reset && state == IDLE) begin
      if (locked) begin
        if (reqValid[owner]) reqReady[owner] = 1'b1;
      end else if (found) begin
        reqReady[pick] = 1'b1;
      end
    end
  end

  assign accept    = |reqReady;
  assign acceptIdx = locked ? owner : pick;
  assign nextPtr   = (owner == OwnW'(NumReq - 1)) ? '0 : owner + OwnW'(1);

  assign wdActive = (state == WAIT && !txDone) ||
                    (state == IDLE && locked && !reqValid[owner]);
  assign wdFire   = WdEnable && wdActive && (wdCount == WdLimit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (accept) stateNext = SEND;
      SEND:    stateNext = WAIT;
      WAIT:    if (txDone || wdFire) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    txValid = (state == SEND);
    busy    = (state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txData     <= '0;
      owner      <= '0;
      locked     <= 1'b0;
      lastHeld   <= 1'b0;
      rrPtr      <= '0;
      wdCount    <= '0;
      timeoutErr <= 1'b0;
    end else begin
      timeoutErr <= wdFire;
      if (accept) begin
        txData   <= reqData[{acceptIdx, 3'b000} +: 8];
        owner    <= acceptIdx;
        lastHeld <= reqLast[acceptIdx];
        locked   <= !reqLast[acceptIdx];
      end
      if (state == WAIT && txDone && lastHeld) begin
        rrPtr  <= nextPtr;
        locked <= 1'b0;
      end
      // Abandon the byte or the stalled packet; the owner loses its turn.
      if (wdFire) begin
        locked <= 1'b0;
        rrPtr  <= nextPtr;
      end
      if (stateNext != state || accept || !wdActive || wdFire) wdCount <= '0;
      else                                                     wdCount <= wdCount + 16'd1;
    end
  end

endmodule
